sequence_detector: RTL and testbench
====================================

Name: sequence_detector

Overview:
- Synchronous pattern detector on a 3-bit input symbol stream; one symbol is sampled per rising clock edge.
- Flags when the last seven sampled symbols are exactly 001, 101, 110, 000, 110, 110, 011, in that order.
- Used as a small standalone control/trigger block; its registered one-cycle pulse feeds downstream logic.

Parameters:
- DATA_W, 3, symbol width. Fixed at 3; the sequence constants are 3-bit.
- COUNT_W, 8, width of the match counter. Used only when SEQ_COUNT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- data  input  3  input symbol, sampled every rising clk edge while reset is low.
- sequence_found  output  1  registered pulse; high for one cycle after the final symbol of the sequence is sampled.
- match_count  output  COUNT_W  completed-match counter. Present only with SEQ_COUNT_EN.

Behaviour:
- State register, 3 bits, encoding progress 0..6:
  - S0: no progress.
  - S1: matched 001.
  - S2: matched 001,101.
  - S3: matched 001,101,110.
  - S4: matched 001,101,110,000.
  - S5: matched 001,101,110,000,110.
  - S6: matched 001,101,110,000,110,110.
- Transitions at each rising edge:
  - Sk with data equal to expected element k+1 -> Sk+1 (k = 0..5).
  - S6 with data = 011 -> S0, and sequence_found <= 1.
  - Any mismatch -> S1 if data = 001, else S0. This is an overlap-aware fallback: 001 occurs only as the first element, so this fallback is exact.
  - Every edge without a completing 011 sets sequence_found <= 0.
- Latency:
  - sequence_found rises on the same edge that samples the 7th symbol.
  - It is visible for exactly one clock period, then returns to 0 unless another match completes.
- Back-to-back matches:
  - The minimum spacing between pulses is 7 cycles.
  - After a match the FSM is in S0; the completing symbol 011 does not count toward the next match.
- Repeated symbols:
  - 110,110,110 while in S5/S6: third 110 from S6 is a mismatch -> S0.
- Reset asserted (any time, including mid-sequence):
  - state <= S0, sequence_found <= 0 immediately, without waiting for clk.
  - Inputs are ignored while reset is high.
  - The first symbol is sampled at the first rising edge after reset deasserts.
- The unused state encoding 7 is treated as S0 on the next edge, with output 0.
- sequence_found is purely registered; no combinational path from data.

Optional Feature:
- Macro: SEQ_COUNT_EN.
- Defined:
  - Adds output match_count (COUNT_W bits), reset to 0 asynchronously.
  - Increments on every edge where sequence_found is set to 1.
  - Saturates at all-ones; no wrap.
- Undefined:
  - No match_count port, no counter logic.
  - sequence_found behaviour is identical in both builds.

Test Plan:
- Reset, release, feed 001,101,110,000,110,110,011,101 -> sequence_found 0 after each of the first six edges, 1 after the 011 edge, 0 after the 101 edge.
- Feed 001,101,110,000,110,110,110 -> sequence_found stays 0; FSM back at S0; then a full sequence produces one pulse on its 011 edge.
- Feed 001,001,101,110,000,110,110,011 -> pulse on the final edge, checking the fallback to S1 on a repeated 001.
- Two full sequences back-to-back (14 symbols) -> exactly two one-cycle pulses, 7 cycles apart.
- Assert reset asynchronously between clock edges after 001,101,110,000,110,110, release, then feed 011 -> no pulse; output and state 0 during reset.
- With SEQ_COUNT_EN and COUNT_W=2: four full matches -> match_count 1,2,3,3 (saturates); reset returns it to 0.

Source files
------------

// File: rtl/sequence_detector_if.sv
// Symbol/flag bundle for sequence_detector.
// Optional match_count signal exists only when SEQ_COUNT_EN is defined.
interface sequence_detector_if #(
  parameter int DATA_W = 3
`ifdef SEQ_COUNT_EN
  ,
  parameter int COUNT_W = 8
`endif
);
  logic [DATA_W-1:0]  data;
  logic               sequence_found;
`ifdef SEQ_COUNT_EN
  logic [COUNT_W-1:0] match_count;
`endif

  // Symbol source: drives data, observes the detector outputs.
  modport master (
    output data,
    input  sequence_found
`ifdef SEQ_COUNT_EN
    ,
    input  match_count
`endif
  );

  // Detector: consumes data, produces the registered flag (and counter).
  modport slave (
    input  data,
    output sequence_found
`ifdef SEQ_COUNT_EN
    ,
    output match_count
`endif
  );
endinterface

// File: rtl/sequence_detector.sv
// Detects the symbol run 001,101,110,000,110,110,011 on a 3-bit stream and
// emits a one-cycle registered pulse on the edge that samples the final 011.
// Optional feature macro: SEQ_COUNT_EN adds a saturating match counter
// (match_count, COUNT_W bits) on the interface.
//
// state | meaning
// ------+-----------------------------------------------
// S0    | no progress
// S1    | matched 001
// S2    | matched 001,101
// S3    | matched 001,101,110
// S4    | matched 001,101,110,000
// S5    | matched 001,101,110,000,110
// S6    | matched 001,101,110,000,110,110
module sequence_detector #(
  parameter int DATA_W = 3
`ifdef SEQ_COUNT_EN
  ,
  parameter int COUNT_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_detector_if.slave   bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_t;

  localparam logic [DATA_W-1:0] E1 = 3'b001;
  localparam logic [DATA_W-1:0] E2 = 3'b101;
  localparam logic [DATA_W-1:0] E3 = 3'b110;
  localparam logic [DATA_W-1:0] E4 = 3'b000;
  localparam logic [DATA_W-1:0] E5 = 3'b110;
  localparam logic [DATA_W-1:0] E6 = 3'b110;
  localparam logic [DATA_W-1:0] E7 = 3'b011;

  state_t state;
  logic   found_q;

`ifdef SEQ_COUNT_EN
  logic [COUNT_W-1:0] count_q;
`endif

  // 001 appears only as the first element, so on a mismatch the only
  // possible partial overlap is a fresh 001.
  function automatic state_t miss_state(input logic [DATA_W-1:0] d);
    return (d == E1) ? S1 : S0;
  endfunction

  // Sequence FSM with registered match pulse (and optional counter).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S0;
      found_q <= 1'b0;
`ifdef SEQ_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      found_q <= 1'b0;
      case (state)
        S0: state <= (bus.data == E1) ? S1 : S0;
        S1: state <= (bus.data == E2) ? S2 : miss_state(bus.data);
        S2: state <= (bus.data == E3) ? S3 : miss_state(bus.data);
        S3: state <= (bus.data == E4) ? S4 : miss_state(bus.data);
        S4: state <= (bus.data == E5) ? S5 : miss_state(bus.data);
        S5: state <= (bus.data == E6) ? S6 : miss_state(bus.data);
        S6: begin
          if (bus.data == E7) begin
            // The completing 011 never starts the next match.
            state   <= S0;
            found_q <= 1'b1;
`ifdef SEQ_COUNT_EN
            if (count_q != '1) count_q <= count_q + 1'b1;
`endif
          end else begin
            state <= miss_state(bus.data);
          end
        end
        default: state <= S0;
      endcase
    end
  end

  assign bus.sequence_found = found_q;
`ifdef SEQ_COUNT_EN
  assign bus.match_count = count_q;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector.
module tb_sequence_detector;

`ifdef SEQ_COUNT_EN
  localparam int CW = 2;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef SEQ_COUNT_EN
  sequence_detector_if #(.DATA_W(3), .COUNT_W(CW)) bus ();
  sequence_detector #(.DATA_W(3), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`else
  sequence_detector_if #(.DATA_W(3)) bus ();
  sequence_detector #(.DATA_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  logic [2:0] full_seq [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_found(input logic exp, input string tag);
    checks++;
    assert (bus.sequence_found === exp) else begin
      errors++;
      $error("FAIL %s found observed=%0b expected=%0b", tag, bus.sequence_found, exp);
    end
  endtask

  task automatic check_state(input logic [2:0] exp, input string tag);
    logic [2:0] st;
    st = dut.state;
    checks++;
    assert (st === exp) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, st, exp);
    end
  endtask

`ifdef SEQ_COUNT_EN
  task automatic check_count(input logic [CW-1:0] exp, input string tag);
    checks++;
    assert (bus.match_count === exp) else begin
      errors++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, bus.match_count, exp);
    end
  endtask
`endif

  // Drive one symbol away from the edge, then check just after the edge.
  task automatic step(input logic [2:0] sym, input logic exp, input string tag);
    @(negedge clk);
    bus.data = sym;
    @(posedge clk);
    #1;
    check_found(exp, tag);
  endtask

  task automatic feed_full(input string tag);
    for (int i = 0; i < 7; i++) step(full_seq[i], (i == 6), tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    full_seq = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011};
    reset = 1'b1;
    bus.data = 3'b000;

    // Reset state
    #12;
    check_found(1'b0, "reset_found");
    check_state(3'd0, "reset_state");
`ifdef SEQ_COUNT_EN
    check_count('0, "reset_count");
`endif
    @(negedge clk);
    reset = 1'b0;

    // Single match followed by a non-matching symbol
    feed_full("t1_seq");
    step(3'b101, 1'b0, "t1_after");

    // Third 110 breaks the run from S6
    for (int i = 0; i < 6; i++) step(full_seq[i], 1'b0, "t2_prefix");
    check_state(3'd6, "t2_at_s6");
    step(3'b110, 1'b0, "t2_third110");
    check_state(3'd0, "t2_back_s0");
    feed_full("t2_recover");

    // Repeated 001 falls back to S1
    step(3'b001, 1'b0, "t3_first001");
    step(3'b001, 1'b0, "t3_second001");
    check_state(3'd1, "t3_fallback_s1");
    for (int i = 1; i < 7; i++) step(full_seq[i], (i == 6), "t3_tail");

    // Two back-to-back matches: pulses exactly 7 cycles apart
    begin
      int pulses;
      int first_at;
      int second_at;
      pulses = 0;
      first_at = -1;
      second_at = -1;
      for (int k = 0; k < 14; k++) begin
        step(full_seq[k % 7], ((k % 7) == 6), "t4_b2b");
        if (bus.sequence_found === 1'b1) begin
          pulses++;
          if (first_at < 0) first_at = k;
          else second_at = k;
        end
      end
      checks++;
      assert (pulses === 2) else begin
        errors++;
        $error("FAIL t4_pulse_count observed=%0d expected=2", pulses);
      end
      checks++;
      assert ((second_at - first_at) === 7) else begin
        errors++;
        $error("FAIL t4_spacing observed=%0d expected=7", second_at - first_at);
      end
    end

    // Async reset mid-sequence, then 011 alone must not match
    for (int i = 0; i < 6; i++) step(full_seq[i], 1'b0, "t5_prefix");
    #2;
    reset = 1'b1;
    #1;
    check_found(1'b0, "t5_in_reset_found");
    check_state(3'd0, "t5_in_reset_state");
    @(negedge clk);
    bus.data = 3'b011;
    @(posedge clk);
    #1;
    check_found(1'b0, "t5_ignored_input");
    check_state(3'd0, "t5_held_s0");
    @(negedge clk);
    reset = 1'b0;
    step(3'b011, 1'b0, "t5_lone011");
    check_state(3'd0, "t5_after_state");

    // Async reset clears a live pulse before the next edge
    feed_full("t6_seq");
    #2;
    reset = 1'b1;
    #1;
    check_found(1'b0, "t6_async_clear");
    @(negedge clk);
    reset = 1'b0;

`ifdef SEQ_COUNT_EN
    // Counter saturates at all-ones for a 2-bit width
    reset = 1'b1;
    #3;
    check_count(2'd0, "t7_cleared");
    @(negedge clk);
    reset = 1'b0;
    feed_full("t7_m1");
    check_count(2'd1, "t7_c1");
    feed_full("t7_m2");
    check_count(2'd2, "t7_c2");
    feed_full("t7_m3");
    check_count(2'd3, "t7_c3");
    feed_full("t7_m4");
    check_count(2'd3, "t7_sat");
    #2;
    reset = 1'b1;
    #1;
    check_count(2'd0, "t7_reset");
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
